// File: rtl/uart_pkg.sv
// Register offsets, STATUS bit positions and FSM state types shared by the mmio_uart blocks.
package uart_pkg;

  localparam logic [2:0] REG_DATA     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_TX_FREE  = 3'd2;
  localparam logic [2:0] REG_RX_COUNT = 3'd3;
  localparam logic [2:0] REG_DIVISOR  = 3'd4;
  localparam logic [2:0] REG_CTRL     = 3'd5;

  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_FULL   = 2;
  localparam int ST_RX_EMPTY  = 3;
  localparam int ST_OVERRUN   = 4;
  localparam int ST_FRAME_ERR = 5;
  localparam int ST_TX_BUSY   = 6;
  localparam int STATUS_BITS  = 7;

  localparam int MIN_DIV = 2;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous first-word-fall-through FIFO; a pop in the same cycle lets a push into a full FIFO.
module fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver: two-flop synchroniser, mid-bit sampling FSM, one-cycle byte/frame-error pulses.
module uart_rx #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             rx_async,
  input  logic [DIV_W-1:0] div,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             frame_err
);
  import uart_pkg::*;

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  rx_state_t        state_q, state_d;
  logic             meta_q, sync_q, prev_q;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tick, fall;

  assign tick = (cnt_q == '0);
  assign fall = prev_q && !sync_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      meta_q  <= rx_async;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (tick || state_q == RX_IDLE) ? cnt_q : cnt_q - ONE;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      RX_IDLE: begin
        if (fall) begin
          state_d = RX_START;
          cnt_d   = (div >> 1) - ONE;
        end
      end
      RX_START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (tick) begin
          if (sync_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            cnt_d   = div - ONE;
            bit_d   = '0;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          shift_d = {sync_q, shift_q[7:1]};
          cnt_d   = div - ONE;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_data   = shift_q;
    rx_valid  = (state_q == RX_STOP) && tick && sync_q;
    frame_err = (state_q == RX_STOP) && tick && !sync_q;
  end

endmodule

// File: rtl/mmio_uart.sv
// MMIO full-duplex 8N1 UART with TX/RX FIFOs; define UART_LOOPBACK_EN to add the CTRL loopback register.
module mmio_uart #(
  parameter int          DATA_WIDTH    = 8,
  parameter int          TX_DEPTH_LOG2 = 4,
  parameter int          RX_DEPTH_LOG2 = 4,
  parameter int          DIV_RESET     = 434,
  parameter logic [31:0] BASE_ADDR     = 32'hFFFFFFF0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_mmio_access,
  input  logic [31:0]           i_mmio_addr,
  input  logic                  i_mmio_write,
  input  logic [DATA_WIDTH-1:0] i_mmio_wdata,
  output logic [DATA_WIDTH-1:0] o_mmio_rdata,
  output logic                  o_hit,
  input  logic                  i_rx,
  output logic                  o_tx
);
  import uart_pkg::*;

  localparam int DIV_W = max_int(DATA_WIDTH, 16);
  localparam logic [DIV_W-1:0] ONE         = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_MIN_VAL = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] DIV_RST_VAL = DIV_W'(DIV_RESET);
  localparam logic [TX_DEPTH_LOG2:0] TX_CAP = {1'b1, {TX_DEPTH_LOG2{1'b0}}};
`ifdef UART_LOOPBACK_EN
  localparam logic [31:0] LAST_OFF = 32'(REG_CTRL);
`else
  localparam logic [31:0] LAST_OFF = 32'(REG_DIVISOR);
`endif

  logic [31:0] offset;
  logic [2:0]  sel;
  logic        act, wr_data, rd_data, wr_status, wr_div;

  assign offset    = i_mmio_addr - BASE_ADDR;
  assign o_hit     = (offset <= LAST_OFF);
  assign sel       = offset[2:0];
  assign act       = i_mmio_access && o_hit;
  assign wr_data   = act && i_mmio_write && (sel == REG_DATA);
  assign rd_data   = act && !i_mmio_write && (sel == REG_DATA);
  assign wr_status = act && i_mmio_write && (sel == REG_STATUS);
  assign wr_div    = act && i_mmio_write && (sel == REG_DIVISOR);

  logic [7:0]             tx_head, rx_head, rx_byte;
  logic                   tx_full, tx_empty, rx_full, rx_empty, tx_pop;
  logic                   rx_valid, rx_ferr, rx_in;
  logic [TX_DEPTH_LOG2:0] tx_count;
  logic [RX_DEPTH_LOG2:0] rx_count;

  fifo #(.WIDTH(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clk   (i_clk),
    .srst  (i_rst),
    .push  (wr_data),
    .wdata (i_mmio_wdata[7:0]),
    .pop   (tx_pop),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  fifo #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .clk   (i_clk),
    .srst  (i_rst),
    .push  (rx_valid),
    .wdata (rx_byte),
    .pop   (rd_data),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  logic [DIV_W-1:0] div_q, div_d, div_wval;
  logic             overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic             ovr_evt;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  uart_rx #(.DIV_W(DIV_W)) u_rx (
    .clk       (i_clk),
    .srst      (i_rst),
    .rx_async  (rx_in),
    .div       (div_q),
    .rx_data   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (rx_ferr)
  );

  // TX FSM; the counter reloads only at bit boundaries so divisor writes never cut a bit short.
  tx_state_t        tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_q, tx_d, tx_tick, tx_busy;

  assign tx_tick = (tx_cnt_q == '0);
  assign tx_busy = (tx_state_q != TX_IDLE);
  assign o_tx    = tx_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_tick ? tx_cnt_q : tx_cnt_q - ONE;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_state_d = TX_START;
          tx_cnt_d   = div_q - ONE;
          tx_shift_d = tx_head;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = div_q - ONE;
          tx_bit_d   = '0;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          tx_cnt_d   = div_q - ONE;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          if (!tx_empty) begin
            tx_state_d = TX_START;
            tx_cnt_d   = div_q - ONE;
            tx_shift_d = tx_head;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_pop = 1'b0;
    tx_d   = tx_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (!tx_empty) begin
          tx_pop = 1'b1;
          tx_d   = 1'b0;
        end
      end
      TX_START: if (tx_tick) tx_d = tx_shift_q[0];
      TX_DATA:  if (tx_tick) tx_d = (tx_bit_q == 3'd7) ? 1'b1 : tx_shift_q[1];
      TX_STOP: begin
        if (tx_tick) begin
          tx_pop = !tx_empty;
          tx_d   = tx_empty;
        end
      end
      default: tx_d = 1'b1;
    endcase
  end

`ifdef UART_LOOPBACK_EN
  logic loop_q, loop_d;
  assign loop_d = (act && i_mmio_write && sel == REG_CTRL) ? i_mmio_wdata[0] : loop_q;
  assign rx_in  = loop_q ? tx_q : i_rx;
  always_ff @(posedge i_clk) begin
    if (i_rst) loop_q <= 1'b0;
    else       loop_q <= loop_d;
  end
`else
  assign rx_in = i_rx;
`endif

  logic [STATUS_BITS-1:0] status;

  always_comb begin
    status               = '0;
    status[ST_TX_FULL]   = tx_full;
    status[ST_TX_EMPTY]  = tx_empty;
    status[ST_RX_FULL]   = rx_full;
    status[ST_RX_EMPTY]  = rx_empty;
    status[ST_OVERRUN]   = overrun_q;
    status[ST_FRAME_ERR] = frame_err_q;
    status[ST_TX_BUSY]   = tx_busy;
  end

  // A new error event wins over a same-cycle write-1-to-clear.
  always_comb begin
    div_wval    = DIV_W'(i_mmio_wdata);
    div_d       = div_q;
    if (wr_div) div_d = (div_wval < DIV_MIN_VAL) ? DIV_MIN_VAL : div_wval;
    ovr_evt     = rx_valid && rx_full && !rd_data;
    overrun_d   = (overrun_q && !(wr_status && i_mmio_wdata[ST_OVERRUN])) || ovr_evt;
    frame_err_d = (frame_err_q && !(wr_status && i_mmio_wdata[ST_FRAME_ERR])) || rx_ferr;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (i_mmio_access && !i_mmio_write) begin
      rdata_d = '0;
      if (o_hit) begin
        case (sel)
          REG_DATA:     rdata_d = rx_empty ? '0 : DATA_WIDTH'(rx_head);
          REG_STATUS:   rdata_d = DATA_WIDTH'(status);
          REG_TX_FREE:  rdata_d = DATA_WIDTH'(TX_CAP - tx_count);
          REG_RX_COUNT: rdata_d = DATA_WIDTH'(rx_count);
          REG_DIVISOR:  rdata_d = div_q[DATA_WIDTH-1:0];
`ifdef UART_LOOPBACK_EN
          REG_CTRL:     rdata_d = DATA_WIDTH'(loop_q);
`endif
          default:      rdata_d = '0;
        endcase
      end
    end
  end

  assign o_mmio_rdata = rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q       <= DIV_RST_VAL;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      div_q       <= div_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule
